// File: rtl/psx_button_conditioner.sv
// psx_button_conditioner: samples the raw active-low PSX button word on a fixed tick,
// debounces each bit on its own, emits press/release pulses and the t_rex game controls.
// Optional D-pad auto-repeat is built only when PSX_AUTOREPEAT_EN is defined.
module psx_button_conditioner #(
  parameter int unsigned SAMPLE_CYCLES  = 20000,
  parameter int unsigned STABLE_SAMPLES = 3,
  parameter int unsigned REPEAT_DELAY   = 250,
  parameter int unsigned REPEAT_RATE    = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] button_state,
  output logic [15:0] pressed,
  output logic [15:0] press_evt,
  output logic [15:0] release_evt,
  output logic        jump,
  output logic        duck,
  output logic        start_evt
);

  localparam int unsigned   TW        = $clog2(SAMPLE_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CYCLES - 1);
  localparam logic [3:0]    STABLE    = 4'(STABLE_SAMPLES);

  // Out-of-range configurations are rejected at elaboration.
  if (SAMPLE_CYCLES < 2 || STABLE_SAMPLES < 1 || STABLE_SAMPLES > 15 ||
      REPEAT_RATE < 1 || REPEAT_DELAY < 1) begin : g_bad_cfg
    $error("psx_button_conditioner: parameter out of range");
  end

  // ------------------------------------------------------------------
  // Sample tick
  // ------------------------------------------------------------------
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  // Free-running sample divider; tick fires on the wrap cycle.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  // ------------------------------------------------------------------
  // Per-bit debounce
  // ------------------------------------------------------------------
  logic [15:0]       raw;
  logic [15:0]       cand_q, cand_d;
  logic [15:0][3:0]  cnt_q, cnt_d;
  logic [15:0]       pressed_q, pressed_d;
  logic [15:0]       press_evt_q, press_evt_d;
  logic [15:0]       release_evt_q, release_evt_d;

  // Track a candidate value per bit and commit it once it has been seen on
  // STABLE_SAMPLES consecutive ticks. Re-committing an unchanged value is harmless,
  // so the commit condition is simply "stability count is full after this tick".
  always_comb begin
    raw       = ~button_state;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    if (tick) begin
      for (int i = 0; i < 16; i++) begin
        if (raw[i] != cand_q[i]) begin
          cand_d[i] = raw[i];
          cnt_d[i]  = 4'd1;
        end else if (cnt_q[i] < STABLE) begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
        if (cnt_d[i] == STABLE) begin
          pressed_d[i] = cand_d[i];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // D-pad auto-repeat (optional)
  // ------------------------------------------------------------------
`ifdef PSX_AUTOREPEAT_EN
  localparam logic [15:0] RPT_DELAY = 16'(REPEAT_DELAY);
  localparam logic [15:0] RPT_RATE  = 16'(REPEAT_RATE);

  logic [15:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_armed_q, rpt_armed_d;
  logic        rpt_fire;
  logic        dpad_one;

  // Count ticks while exactly one direction is held and unchanged; the first repeat
  // waits REPEAT_DELAY ticks, later ones REPEAT_RATE. Any D-pad change restarts it, which
  // also guarantees a repeat never lands on the same tick as a commit of that bit.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
    rpt_fire    = 1'b0;
    dpad_one    = $onehot(pressed_q[7:4]);
    if (tick) begin
      if (!dpad_one || (pressed_d[7:4] != pressed_q[7:4])) begin
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 16'd1;
        if (rpt_cnt_d == (rpt_armed_q ? RPT_RATE : RPT_DELAY)) begin
          rpt_fire    = 1'b1;
          rpt_cnt_d   = '0;
          rpt_armed_d = 1'b1;
        end
      end
    end
  end

  // Repeat counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
`endif

  // ------------------------------------------------------------------
  // Events
  // ------------------------------------------------------------------

  // Edges of the committed vector, registered alongside it so each pulse is one cycle.
  always_comb begin
    press_evt_d   = pressed_d & ~pressed_q;
    release_evt_d = pressed_q & ~pressed_d;
`ifdef PSX_AUTOREPEAT_EN
    if (rpt_fire) begin
      press_evt_d = press_evt_d | {8'h00, pressed_q[7:4], 4'h0};
    end
`endif
  end

  // Tick divider, debounce and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q    <= '0;
      cand_q        <= '0;
      cnt_q         <= '0;
      pressed_q     <= '0;
      press_evt_q   <= '0;
      release_evt_q <= '0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      pressed_q     <= pressed_d;
      press_evt_q   <= press_evt_d;
      release_evt_q <= release_evt_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs; game controls are decoded straight from the registered state.
  // ------------------------------------------------------------------
  assign pressed     = pressed_q;
  assign press_evt   = press_evt_q;
  assign release_evt = release_evt_q;
  assign jump        = pressed_q[14] | pressed_q[4];
  assign duck        = pressed_q[6] & ~jump;
  assign start_evt   = press_evt_q[3];

endmodule

// File: tb/tb_psx_button_conditioner.sv
// Bench for psx_button_conditioner: table vectors, hand-written corner sequences and
// randomized stimulus against a sample-window reference model.
module tb_psx_button_conditioner;
  localparam int SC = 4;
  localparam int SS = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] button_state = 16'hFFFF;
  logic [15:0] pressed, press_evt, release_evt;
  logic        jump, duck, start_evt;

  always #5 clk = ~clk;

  psx_button_conditioner #(
    .SAMPLE_CYCLES(SC), .STABLE_SAMPLES(SS), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .button_state(button_state),
    .pressed(pressed), .press_evt(press_evt), .release_evt(release_evt),
    .jump(jump), .duck(duck), .start_evt(start_evt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pressed bit = value of the last SS samples when they all agree.
  logic [15:0] m_p, m_pe, m_re;
  logic [15:0] m_hist[$];
  int          m_edges;
  int          m_rc;

  function automatic void model_reset();
    m_p = '0; m_pe = '0; m_re = '0;
    m_hist.delete();
    m_edges = 0;
    m_rc = 0;
  endfunction

  function automatic void model_edge(input logic [15:0] bs);
    logic [15:0] np;
    logic        same;
    m_edges++;
    m_pe = '0;
    m_re = '0;
    if (m_edges % SC != 0) return;
    m_hist.push_back(~bs);
    if (m_hist.size() > SS) void'(m_hist.pop_front());
    np = m_p;
    if (m_hist.size() == SS) begin
      for (int i = 0; i < 16; i++) begin
        same = 1'b1;
        for (int j = 1; j < SS; j++) if (m_hist[j][i] != m_hist[0][i]) same = 1'b0;
        if (same) np[i] = m_hist[0][i];
      end
    end
    m_pe = np & ~m_p;
    m_re = m_p & ~np;
`ifdef PSX_AUTOREPEAT_EN
    if (np[7:4] != m_p[7:4] || $countones(m_p[7:4]) != 1) begin
      m_rc = 0;
    end else begin
      m_rc++;
      if (m_rc == RD || (m_rc > RD && (m_rc - RD) % RR == 0))
        m_pe = m_pe | {8'h00, m_p[7:4], 4'h0};
    end
`endif
    m_p = np;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic ej;
    ej = m_p[14] | m_p[4];
    chk("pressed", pressed, m_p);
    chk("press_evt", press_evt, m_pe);
    chk("release_evt", release_evt, m_re);
    chk("jump", 16'(jump), 16'(ej));
    chk("duck", 16'(duck), 16'(m_p[6] & ~ej));
    chk("start_evt", 16'(start_evt), 16'(m_pe[3]));
  endtask

  // One clock with the given input, model advanced, outputs compared 1 time unit later.
  task automatic cyc(input logic [15:0] bs);
    button_state = bs;
    @(posedge clk);
    if (!rst) model_edge(bs);
    #1;
    check_all();
  endtask

  task automatic apply_reset(input logic [15:0] bs);
    button_state = bs;
    rst = 1'b1;
    #1;
    model_reset();
    chk("reset_pressed", pressed, 16'h0000);
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0] bs;
    logic [15:0] exp_pressed;
    logic        exp_jump;
    logic        exp_duck;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t        tbl[8];
    int          k, found, evcnt, c0;
    int          offs[$];
    logic        seen_bad;
    logic [15:0] cur;

    tbl[0] = '{16'hFFFF, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{16'hBFFF, 16'h4000, 1'b1, 1'b0};
    tbl[2] = '{16'hFFBF, 16'h0040, 1'b0, 1'b1};
    tbl[3] = '{16'hBFBF, 16'h4040, 1'b1, 1'b0};
    tbl[4] = '{16'hFFAF, 16'h0050, 1'b1, 1'b0};
    tbl[5] = '{16'hFFF7, 16'h0008, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'hFFFF, 1'b1, 1'b0};
    tbl[7] = '{16'hFFFF, 16'h0000, 1'b0, 1'b0};

    apply_reset(16'hFFFF);

    // 1: idle pad, nothing commits.
    evcnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(16'hFFFF);
      if ((press_evt | release_evt) != 0 || pressed != 0) evcnt++;
    end
    chk_int("t1_idle_activity", evcnt, 0);

    // 2: Cross; 40 cycles after reset the next tick is 4 cycles away, commit 2 ticks later.
    found = 0;
    for (k = 1; k <= 20 && found == 0; k++) begin
      cyc(16'hBFFF);
      if (press_evt != 0) found = k;
    end
    chk_int("t2_commit_cycle", found, 12);
    chk("t2_press_evt", press_evt, 16'h4000);
    chk("t2_jump", 16'(jump), 16'h0001);
    cyc(16'hBFFF);
    chk("t2_evt_width", press_evt, 16'h0000);
    chk("t2_pressed", pressed, 16'h4000);

    // 3: glitch of exactly two ticks never commits.
    repeat (20) cyc(16'hFFFF);
    seen_bad = 1'b0;
    repeat (8) begin
      cyc(16'hBFFF);
      if ((press_evt | release_evt | pressed) != 0) seen_bad = 1'b1;
    end
    repeat (24) begin
      cyc(16'hFFFF);
      if ((press_evt | release_evt | pressed) != 0) seen_bad = 1'b1;
    end
    chk("t3_glitch_activity", 16'(seen_bad), 16'h0000);

    // 4: Cross -> Down in one step: release and press in the same cycle.
    repeat (20) cyc(16'hBFFF);
    found = 0;
    for (k = 1; k <= 20 && found == 0; k++) begin
      cyc(16'hFFBF);
      if (release_evt != 0) found = k;
    end
    chk_int("t4_found", (found != 0) ? 1 : 0, 1);
    chk("t4_release_evt", release_evt, 16'h4000);
    chk("t4_press_evt", press_evt, 16'h0040);
    chk("t4_duck", 16'(duck), 16'h0001);
    chk("t4_jump", 16'(jump), 16'h0000);

    // 5: Up held; auto-repeat pulses at +5, +7, +9 ticks when enabled.
    repeat (20) cyc(16'hFFFF);
    c0 = 0;
    offs.delete();
    for (k = 1; k <= 20 && c0 == 0; k++) begin
      cyc(16'hFFEF);
      if (press_evt[4]) c0 = k;
    end
    chk_int("t5_commit_found", (c0 != 0) ? 1 : 0, 1);
    for (k = 1; k <= 40; k++) begin
      cyc(16'hFFEF);
      if (press_evt[4]) offs.push_back(k);
    end
`ifdef PSX_AUTOREPEAT_EN
    chk_int("t5_repeat_count", offs.size(), 3);
    if (offs.size() == 3) begin
      chk_int("t5_rep1", offs[0], 5 * SC);
      chk_int("t5_rep2", offs[1], 7 * SC);
      chk_int("t5_rep3", offs[2], 9 * SC);
    end
`else
    chk_int("t5_repeat_count", offs.size(), 0);
`endif

    // 6: reset while Start is held; fresh press 3 ticks after release, no release pulse.
    repeat (20) cyc(16'hFFF7);
    chk("t6_pre_pressed", pressed, 16'h0008);
    apply_reset(16'hFFF7);
    found = 0;
    evcnt = 0;
    seen_bad = 1'b0;
    for (k = 1; k <= 40; k++) begin
      cyc(16'hFFF7);
      if (start_evt) begin
        evcnt++;
        if (found == 0) found = k;
      end
      if (release_evt != 0) seen_bad = 1'b1;
    end
    chk_int("t6_start_cycle", found, 3 * SC);
    chk_int("t6_start_count", evcnt, 1);
    chk("t6_no_release", 16'(seen_bad), 16'h0000);

    // Table vectors: settled levels of pressed/jump/duck.
    for (int t = 0; t < 8; t++) begin
      repeat (20) cyc(tbl[t].bs);
      chk("tbl_pressed", pressed, tbl[t].exp_pressed);
      chk("tbl_jump", 16'(jump), 16'(tbl[t].exp_jump));
      chk("tbl_duck", 16'(duck), 16'(tbl[t].exp_duck));
    end

    // Randomized stimulus: slow bit flips biased to the D-pad, short glitches,
    // disconnect frames and occasional resets.
    apply_reset(16'hFFFF);
    cur = 16'hFFFF;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 699) == 0) apply_reset(cur);
      if ($urandom_range(0, 23) == 0) begin
        if ($urandom_range(0, 1) == 1) cur[$urandom_range(4, 7)] ^= 1'b1;
        else cur[$urandom_range(0, 15)] ^= 1'b1;
      end
      if ($urandom_range(0, 399) == 0) cur = 16'hFFFF;
      if ($urandom_range(0, 49) == 0) begin
        k = $urandom_range(1, 10);
        repeat (k) cyc(cur ^ 16'(1 << $urandom_range(0, 15)));
      end else begin
        cyc(cur);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
